// File: rtl/hdlc_mon_pkg.sv
// HDLC Rx line monitor: shared types and constants.
// Decode thresholds, FSM states and ErrFlags bit positions.
package hdlc_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        ABORT = 2'd2
    } monState_t;

    localparam logic [2:0] FLAG_ONES  = 3'd6;
    localparam logic [2:0] ABORT_ONES = 3'd7;
    localparam logic [2:0] STUFF_ONES = 3'd5;

    localparam int ERR_FLAG  = 0;
    localparam int ERR_ABORT = 1;
    localparam int ERR_ALIGN = 2;
    localparam int ERR_OVF   = 3;
    localparam int ERR_EOF   = 4;
    localparam int ERR_BITS  = 5;

endpackage

// File: rtl/hdlc_rx_line_monitor_ch.sv
// HDLC Rx line monitor: one channel.
// Decodes the line, closes frames and cross-checks the DUT detects.
module hdlc_rx_line_monitor_ch
    import hdlc_mon_pkg::*;
#(
    parameter int CNT_WIDTH       = 16,
    parameter int MAX_FRAME_BYTES = 128,
    parameter int DET_LATENCY     = 2,
    parameter int EOF_WINDOW      = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Clear,
    input  logic                 RxEN,
    input  logic                 Rx,
    input  logic                 Rx_FlagDetect,
    input  logic                 Rx_AbortDetect,
    input  logic                 Rx_EoF,
    output logic [CNT_WIDTH-1:0] FrameCnt,
    output logic [CNT_WIDTH-1:0] ErrCnt,
    output logic [ERR_BITS-1:0]  ErrFlags,
    output logic [7:0]           FrameBytes,
    output logic                 FrameDone
);

    localparam int MAX_BITS = MAX_FRAME_BYTES * 8;
    localparam int BIT_SAT  = MAX_BITS + 15;
    localparam int BW       = $clog2(BIT_SAT + 1);
    localparam int TW       = $clog2(EOF_WINDOW + 1);

    monState_t              state;
    logic [2:0]             ones;
    logic [BW-1:0]          bitCnt;
    logic [DET_LATENCY-1:0] flagQ;
    logic [DET_LATENCY-1:0] abortQ;
    logic [TW-1:0]          eofTmr;
    logic                   eofPrev;

    logic                   flagEv;
    logic                   abortEv;
    logic                   stuffEv;
    logic                   closeEv;
    logic                   misAlign;
    logic                   overFlow;
    logic                   goodFrame;
    logic                   eofRise;
    logic [BW-1:0]          payload;
    logic [ERR_BITS-1:0]    errVec;
    logic [2:0]             errInc;
    logic [CNT_WIDTH:0]     errSum;

    // Line events, frame close classification and this cycle's errors
    always_comb begin
        flagEv    = RxEN && !Rx && (ones == FLAG_ONES);
        abortEv   = RxEN && Rx && (ones == ABORT_ONES - 3'd1);
        stuffEv   = !Rx && (ones == STUFF_ONES);
        closeEv   = flagEv && (state == FRAME) && (bitCnt > BW'(7));
        payload   = bitCnt - BW'(7);
        misAlign  = closeEv && (payload[2:0] != 3'd0);
        overFlow  = closeEv && (payload > BW'(MAX_BITS));
        goodFrame = closeEv && !misAlign && !overFlow;
        eofRise   = Rx_EoF && !eofPrev;
        errVec            = '0;
        errVec[ERR_FLAG]  = RxEN && (flagQ[DET_LATENCY-1] != Rx_FlagDetect);
        errVec[ERR_ABORT] = RxEN && (abortQ[DET_LATENCY-1] != Rx_AbortDetect);
        errVec[ERR_ALIGN] = misAlign;
        errVec[ERR_OVF]   = overFlow;
        errVec[ERR_EOF]   = RxEN && (eofTmr == TW'(1)) && !eofRise;
        errInc = 3'($countones(errVec));
        errSum = {1'b0, ErrCnt} + (CNT_WIDTH + 1)'(errInc);
    end

    // Line decode, frame FSM and pending-check pipelines
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state   <= IDLE;
            ones    <= '0;
            bitCnt  <= '0;
            flagQ   <= '0;
            abortQ  <= '0;
            eofTmr  <= '0;
            eofPrev <= 1'b0;
        end else begin
            eofPrev <= Rx_EoF;
            if (!RxEN) begin
                state  <= IDLE;
                ones   <= '0;
                bitCnt <= '0;
                flagQ  <= '0;
                abortQ <= '0;
                eofTmr <= '0;
            end else begin
                if (!Rx) ones <= 3'd0;
                else if (ones != ABORT_ONES) ones <= ones + 3'd1;
                flagQ  <= (flagQ << 1) | DET_LATENCY'(flagEv);
                abortQ <= (abortQ << 1) | DET_LATENCY'(abortEv && state == FRAME);
                if (closeEv) eofTmr <= TW'(EOF_WINDOW);
                else if (eofTmr != '0) eofTmr <= eofRise ? '0 : eofTmr - TW'(1);
                unique case (state)
                    IDLE, ABORT: begin
                        if (flagEv) begin
                            state  <= FRAME;
                            bitCnt <= '0;
                        end
                    end
                    FRAME: begin
                        if (flagEv) bitCnt <= '0;
                        else if (abortEv) state <= ABORT;
                        else if (!stuffEv && bitCnt != BW'(BIT_SAT))
                            bitCnt <= bitCnt + BW'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Saturating counters, sticky flags and per-frame results
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            FrameCnt   <= '0;
            ErrCnt     <= '0;
            ErrFlags   <= '0;
            FrameBytes <= '0;
            FrameDone  <= 1'b0;
        end else if (Clear) begin
            FrameCnt   <= '0;
            ErrCnt     <= '0;
            ErrFlags   <= '0;
            FrameBytes <= '0;
            FrameDone  <= 1'b0;
        end else begin
            FrameDone <= closeEv;
            if (closeEv) FrameBytes <= overFlow ? 8'hFF : 8'(payload >> 3);
            if (goodFrame && FrameCnt != '1) FrameCnt <= FrameCnt + CNT_WIDTH'(1);
            ErrCnt   <= errSum[CNT_WIDTH] ? '1 : errSum[CNT_WIDTH-1:0];
            ErrFlags <= ErrFlags | errVec;
        end
    end

endmodule

// File: rtl/hdlc_rx_line_monitor.sv
// HDLC Rx line monitor: multi-channel top.
// One independent monitor lane per Rx line.
module hdlc_rx_line_monitor
    import hdlc_mon_pkg::*;
#(
    parameter int CHANNELS        = 1,
    parameter int CNT_WIDTH       = 16,
    parameter int MAX_FRAME_BYTES = 128,
    parameter int DET_LATENCY     = 2,
    parameter int EOF_WINDOW      = 4
) (
    input  logic                               Clk,
    input  logic                               Rst,
    input  logic                               Clear,
    input  logic [CHANNELS-1:0]                RxEN,
    input  logic [CHANNELS-1:0]                Rx,
    input  logic [CHANNELS-1:0]                Rx_FlagDetect,
    input  logic [CHANNELS-1:0]                Rx_AbortDetect,
    input  logic [CHANNELS-1:0]                Rx_EoF,
    output logic [CHANNELS-1:0][CNT_WIDTH-1:0] FrameCnt,
    output logic [CHANNELS-1:0][CNT_WIDTH-1:0] ErrCnt,
    output logic [CHANNELS-1:0][ERR_BITS-1:0]  ErrFlags,
    output logic [CHANNELS-1:0][7:0]           FrameBytes,
    output logic [CHANNELS-1:0]                FrameDone
);

    for (genvar c = 0; c < CHANNELS; c++) begin : gCh
        hdlc_rx_line_monitor_ch #(
            .CNT_WIDTH      (CNT_WIDTH),
            .MAX_FRAME_BYTES(MAX_FRAME_BYTES),
            .DET_LATENCY    (DET_LATENCY),
            .EOF_WINDOW     (EOF_WINDOW)
        ) uCh (
            .Clk           (Clk),
            .Rst           (Rst),
            .Clear         (Clear),
            .RxEN          (RxEN[c]),
            .Rx            (Rx[c]),
            .Rx_FlagDetect (Rx_FlagDetect[c]),
            .Rx_AbortDetect(Rx_AbortDetect[c]),
            .Rx_EoF        (Rx_EoF[c]),
            .FrameCnt      (FrameCnt[c]),
            .ErrCnt        (ErrCnt[c]),
            .ErrFlags      (ErrFlags[c]),
            .FrameBytes    (FrameBytes[c]),
            .FrameDone     (FrameDone[c])
        );
    end

endmodule

// File: doc/hdlc_rx_line_monitor.md
Name: hdlc_rx_line_monitor

Overview:
- Synthesizable, multi-channel HDLC receive-line monitor; the successor to the simulation-only Rx concurrent checks.
- Per channel it independently decodes the serial Rx line (one bit per Clk): flags, aborts, idle and zero-stuffing.
- It tracks frame length and alignment, and cross-checks the DUT's Rx_FlagDetect, Rx_AbortDetect and Rx_EoF against its own decode.
- Results go to saturating per-channel counters and sticky error flags; it sits beside the Rx core in test and debug builds.

Parameters:
CHANNELS, 1, number of independent Rx lines monitored
CNT_WIDTH, 16, width of each frame/error counter (saturating)
MAX_FRAME_BYTES, 128, payload bytes allowed before overflow error
DET_LATENCY, 2, cycles from end of decoded flag/abort pattern to the expected DUT detect pulse
EOF_WINDOW, 4, max cycles from decoded closing flag to DUT Rx_EoF rise

Ports:
Clk  in  1  clock
Rst  in  1  asynchronous active-low reset
Clear  in  1  synchronous clear of all counters and sticky flags (all channels)
RxEN  in  CHANNELS  per-channel monitor enable; low holds the channel in IDLE with counters frozen
Rx  in  CHANNELS  serial line per channel, sampled every posedge Clk
Rx_FlagDetect  in  CHANNELS  DUT flag-detect per channel
Rx_AbortDetect  in  CHANNELS  DUT abort-detect per channel
Rx_EoF  in  CHANNELS  DUT end-of-frame per channel
FrameCnt  out  CHANNELS x CNT_WIDTH  good frames decoded (aligned, no overflow, not aborted)
ErrCnt  out  CHANNELS x CNT_WIDTH  total error events
ErrFlags  out  CHANNELS x 5  sticky: [0] flag mismatch, [1] abort mismatch, [2] non-aligned, [3] overflow, [4] EoF missing
FrameBytes  out  CHANNELS x 8  payload byte count of the last closed frame
FrameDone  out  CHANNELS  1-cycle pulse when a frame closes (good or bad)

Behaviour:
- Reset (Rst=0): every channel goes to IDLE; FrameCnt, ErrCnt, ErrFlags, FrameBytes, FrameDone, shift register, ones counter, bit counter and check timers all go to 0.
- Clear has the same effect on counters and flags only; the FSM and decode state are untouched. Clear wins over a same-cycle increment.
- Decode, per channel, each cycle with RxEN=1:
  - ones counter: counts consecutive 1s, resets on 0, saturates at 7.
  - Flag event: bit=0 with ones==6.
  - Abort event: ones reaches 7.
  - Stuffed zero: bit=0 with ones==5; it is dropped and not counted.
  - Every other bit in FRAME increments the bit counter, which saturates at MAX_FRAME_BYTES*8+15.
- FSM states:
  - IDLE: flag event -> FRAME with the bit counter cleared. An abort event here is not an error.
  - FRAME: flag event -> close frame, then stay in FRAME with the counter cleared (back-to-back frames share one flag). Abort event -> ABORT.
  - ABORT: remains until a flag event -> FRAME.
- Close of frame:
  - payload bits P = bitcnt-7, because the flag's leading 0 and six 1s were counted.
  - P==0: empty gap between flags; no FrameDone, nothing counted.
  - P%8!=0: set flag[2] and increment ErrCnt.
  - P>MAX_FRAME_BYTES*8: set flag[3] and increment ErrCnt; FrameBytes saturates at 255.
  - Otherwise FrameBytes=P/8 and FrameCnt increments.
  - FrameDone pulses in the cycle after the event in all cases except P==0.
- Flag cross-check: a decoded flag event at cycle t requires Rx_FlagDetect=1 at t+DET_LATENCY. A DUT FlagDetect with no matching event at t-DET_LATENCY is also a mismatch. Either case sets flag[0] and increments ErrCnt.
- Abort cross-check: identical rule against Rx_AbortDetect, applied only to abort events in FRAME; sets flag[1].
- EoF check: after a non-empty close, Rx_EoF must rise within EOF_WINDOW cycles, else set flag[4] and increment ErrCnt once.
- Error increments: several errors in one cycle on one channel add 1 per error; ErrCnt saturates at all-ones.
- RxEN falling mid-frame: the channel returns to IDLE with no close and no error; pending checks are cancelled.
- Channels are fully independent; there are no shared resources.

Decomposition:
- Package hdlc_mon_pkg holds:
  - the state enum (IDLE, FRAME, ABORT);
  - constants FLAG_ONES=6, ABORT_ONES=7, STUFF_ONES=5;
  - ErrFlags bit-index localparams.
- Sub-module hdlc_rx_line_monitor_ch implements one channel. It is generate-instantiated CHANNELS times; the top holds only the generate loop and output packing.
- Expected-detect tracking is a DET_LATENCY-deep shift register inside the channel.

Test Plan:
- Single frame: idle 1s, flag, 3 bytes 0xA5 0x3C 0x81, flag, DUT detects at +2 and EoF at +3 -> FrameCnt=1, FrameBytes=3, ErrFlags=0, one FrameDone pulse.
- Zero stuffing: payload 0xFF 0xFF on the line with stuffed zeros -> FrameBytes=2, no alignment error; stuffed bits are not counted.
- Abort mid-frame: flag, 10 data bits, 0 then seven 1s, DUT AbortDetect at +2 -> no FrameCnt change, ErrCnt=0, state ABORT; next flag returns to FRAME.
- Detect mismatch: flag with DUT FlagDetect at +3 instead of +2 -> flag[0] set, ErrCnt=2 (one missing, one spurious).
- Overflow and misalignment: 129-byte frame -> flag[3], FrameBytes=255. Separately, a 3-byte+5-bit frame -> flag[2].
- Channels, Clear and reset: CHANNELS=4 with different traffic per lane, ch2 RxEN=0 -> ch2 counters stay 0. Clear pulse -> all zero. Async Rst asserted mid-frame -> outputs 0 immediately.
